// File: rtl/exec_pkg.sv
// Shared types for the rv32i execute stage: ALU/branch op encodings and FSM states.
package exec_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   // Branch funct3 encodings; 010/011 are not listed and are never taken.
   typedef enum logic [2:0] {
      BR_BEQ  = 3'b000,
      BR_BNE  = 3'b001,
      BR_BLT  = 3'b100,
      BR_BGE  = 3'b101,
      BR_BLTU = 3'b110,
      BR_BGEU = 3'b111
   } br_op_t;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   function automatic logic is_shift_op(alu_op_t op);
      return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
   endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the execute stage, including a single-cycle barrel shifter.
module exec_alu
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  alu_op_t         op,
   output logic [XLEN-1:0] y
);

   localparam int SHW = $clog2(XLEN);

   logic [SHW-1:0] shamt;
   assign shamt = b[SHW-1:0];

   // Select the ALU result; unlisted encodings (10-15) produce zero.
   always_comb begin
      // NOTE: assign a default before the case so no path leaves y unassigned (avoids a latch).
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << shamt;
         ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
         ALU_SLTU: y = XLEN'(a < b);
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> shamt;
         ALU_SRA:  y = $signed(a) >>> shamt;
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         default:  y = '0;
      endcase
   end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: owns the PC, evaluates ALU ops, branches and jumps, with
// valid/ready handshakes on both sides and an optional serial shift engine.
module exec_stage
   import exec_pkg::*;
#(
   parameter int              XLEN         = 32,
   parameter int unsigned     PC_INCR      = 4,
   parameter logic [XLEN-1:0] PC_INIT      = '0,
   parameter bit              SERIAL_SHIFT = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   input  logic [XLEN-1:0] i_imm,
   input  logic            i_imm_sel,
   input  logic [3:0]      i_alu_op,
   input  logic [2:0]      i_br_op,
   input  logic            i_is_branch,
   input  logic            i_is_jal,
   input  logic            i_is_jalr,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_result,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_pc
);

   localparam int SHW = $clog2(XLEN);

   state_t          state;
   logic [SHW-1:0]  cnt;
   logic [XLEN-1:0] work;
   logic [XLEN-1:0] work_next;
   alu_op_t         sh_op;
   logic            sh_redirect;

   alu_op_t         alu_op;
   logic [XLEN-1:0] op_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] alu_y;
   logic            br_taken;
   logic            redirect;
   logic [XLEN-1:0] link;
   logic [XLEN-1:0] next_pc;
   logic [XLEN-1:0] new_result;
   logic            start_serial;
   logic            accept;

   assign alu_op = alu_op_t'(i_alu_op);
   assign op_b   = i_imm_sel ? i_imm : i_rs2;
   assign shamt  = op_b[SHW-1:0];

   exec_alu #(.XLEN(XLEN)) u_alu (
      .a  (i_rs1),
      .b  (op_b),
      .op (alu_op),
      .y  (alu_y)
   );

   // Branch condition always compares rs1 against rs2, independent of the ALU operand mux.
   always_comb begin
      br_taken = 1'b0;
      case (br_op_t'(i_br_op))
         BR_BEQ:  br_taken = (i_rs1 == i_rs2);
         BR_BNE:  br_taken = (i_rs1 != i_rs2);
         BR_BLT:  br_taken = ($signed(i_rs1) <  $signed(i_rs2));
         BR_BGE:  br_taken = ($signed(i_rs1) >= $signed(i_rs2));
         BR_BLTU: br_taken = (i_rs1 <  i_rs2);
         BR_BGEU: br_taken = (i_rs1 >= i_rs2);
         default: br_taken = 1'b0;
      endcase
   end

   assign redirect = i_is_jal | i_is_jalr | (i_is_branch & br_taken);
   assign link     = o_pc + XLEN'(PC_INCR);

   // Next PC: jump/branch target or sequential increment, all modulo 2^XLEN.
   always_comb begin
      next_pc = link;
      if (i_is_jal)
         next_pc = o_pc + i_imm;
      else if (i_is_jalr)
         next_pc = (i_rs1 + i_imm) & ~XLEN'(1);
      else if (i_is_branch && br_taken)
         next_pc = o_pc + i_imm;
   end

   // A zero-distance shift leaves operand A unchanged, so the barrel result is
   // exact for it even in serial mode; only non-zero shifts enter the engine.
   // Jumps carry the link address, so they never occupy the shift engine.
   assign new_result   = (i_is_jal || i_is_jalr) ? link : alu_y;
   assign start_serial = SERIAL_SHIFT && is_shift_op(alu_op) && (shamt != '0)
                         && !i_is_jal && !i_is_jalr;

   assign o_ready = (state == IDLE) && (!o_valid || i_ready);
   assign accept  = i_valid && o_ready;

   // One-bit step of the serial shifter; SRA replicates the sign bit.
   always_comb begin
      work_next = work;
      case (sh_op)
         ALU_SLL: work_next = {work[XLEN-2:0], 1'b0};
         ALU_SRL: work_next = {1'b0, work[XLEN-1:1]};
         ALU_SRA: work_next = {work[XLEN-1], work[XLEN-1:1]};
         default: work_next = work;
      endcase
   end

   // PC, shift FSM and output register; a result load wins over the output handshake.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         work        <= '0;
         sh_op       <= ALU_ADD;
         sh_redirect <= 1'b0;
         o_pc        <= PC_INIT;
         o_valid     <= 1'b0;
         o_result    <= '0;
         o_redirect  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments only, so the later load below overrides this clear cleanly.
         if (o_valid && i_ready)
            o_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (accept) begin
                  o_pc <= next_pc;
                  if (start_serial) begin
                     state       <= SHIFT;
                     cnt         <= shamt;
                     work        <= i_rs1;
                     sh_op       <= alu_op;
                     sh_redirect <= redirect;
                  end else begin
                     o_result   <= new_result;
                     o_redirect <= redirect;
                     o_valid    <= 1'b1;
                  end
               end
            end
            SHIFT: begin
               work <= work_next;
               cnt  <= cnt - SHW'(1);
               if (cnt == SHW'(1)) begin
                  state      <= IDLE;
                  o_result   <= work_next;
                  o_redirect <= sh_redirect;
                  o_valid    <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_exec_stage.sv
// Directed self-checking bench for exec_stage (default parameters, serial shifts).
module tb_exec_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_rs1, i_rs2, i_imm;
   logic        i_imm_sel;
   logic [3:0]  i_alu_op;
   logic [2:0]  i_br_op;
   logic        i_is_branch, i_is_jal, i_is_jalr;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_result;
   logic        o_redirect;
   logic [31:0] o_pc;

   int checks = 0;
   int errors = 0;
   logic seen_valid;

   exec_stage dut (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .i_imm       (i_imm),
      .i_imm_sel   (i_imm_sel),
      .i_alu_op    (i_alu_op),
      .i_br_op     (i_br_op),
      .i_is_branch (i_is_branch),
      .i_is_jal    (i_is_jal),
      .i_is_jalr   (i_is_jalr),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_result    (o_result),
      .o_redirect  (o_redirect),
      .o_pc        (o_pc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Present one op; called at a falling edge.
   task automatic set_op(input logic [3:0] alu, input logic [2:0] br, input logic isb,
                         input logic jal, input logic jalr, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic isel);
      i_valid     = 1'b1;
      i_alu_op    = alu;
      i_br_op     = br;
      i_is_branch = isb;
      i_is_jal    = jal;
      i_is_jalr   = jalr;
      i_rs1       = rs1;
      i_rs2       = rs2;
      i_imm       = imm;
      i_imm_sel   = isel;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      i_ready = 1'b1;
      set_op(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      i_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_pc", o_pc, 32'h0);
      check("rst_valid", o_valid, 1'b0);
      check("rst_result", o_result, 32'h0);
      check("rst_redirect", o_redirect, 1'b0);
      check("rst_ready", o_ready, 1'b1);
      rst = 1'b0;
      @(negedge clk);

      // ADD 5 + imm 7
      set_op(4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd7, 1'b1);
      step();
      i_valid = 1'b0;
      check("add_result", o_result, 32'd12);
      check("add_valid", o_valid, 1'b1);
      check("add_pc", o_pc, 32'h4);
      check("add_redirect", o_redirect, 1'b0);

      // Serial SRA by 4
      set_op(4'd7, 3'd0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
      step();
      i_valid = 1'b0;
      check("sra_ready0", o_ready, 1'b0);
      check("sra_valid0", o_valid, 1'b0);
      check("sra_pc", o_pc, 32'h8);
      for (int c = 1; c < 4; c++) begin
         step();
         check("sra_ready_busy", o_ready, 1'b0);
      end
      step();
      check("sra_valid", o_valid, 1'b1);
      check("sra_result", o_result, 32'hF800_0000);
      check("sra_ready_after", o_ready, 1'b1);

      // Serial SRL by 4
      set_op(4'd6, 3'd0, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'd4, 32'd0, 1'b0);
      step();
      i_valid = 1'b0;
      check("srl_ready0", o_ready, 1'b0);
      repeat (3) step();
      check("srl_valid_early", o_valid, 1'b0);
      step();
      check("srl_valid", o_valid, 1'b1);
      check("srl_result", o_result, 32'h0800_0000);
      check("srl_pc", o_pc, 32'hC);

      // BLT taken (-1 < 1)
      set_op(4'd0, 3'b100, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
      step();
      check("blt_pc", o_pc, 32'h1C);
      check("blt_redirect", o_redirect, 1'b1);
      check("blt_valid", o_valid, 1'b1);

      // BLTU not taken (0xFFFFFFFF >= 1 unsigned)
      set_op(4'd0, 3'b110, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
      step();
      check("bltu_pc", o_pc, 32'h20);
      check("bltu_redirect", o_redirect, 1'b0);

      // JALR clears bit 0 of the target
      set_op(4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 32'h101, 32'd0, 32'd2, 1'b1);
      step();
      check("jalr_pc", o_pc, 32'h102);
      check("jalr_result", o_result, 32'h24);
      check("jalr_redirect", o_redirect, 1'b1);

      // XOR, then backpressure with a second op waiting
      set_op(4'd5, 3'd0, 1'b0, 1'b0, 1'b0, 32'hF0F0, 32'h0FF0, 32'd0, 1'b0);
      step();
      check("xor_result", o_result, 32'hFF00);
      check("xor_pc", o_pc, 32'h106);
      check("xor_redirect", o_redirect, 1'b0);
      set_op(4'd9, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFF, 32'd0, 32'h0F, 1'b1);
      i_ready = 1'b0;
      #1;
      check("bp_ready_now", o_ready, 1'b0);
      for (int c = 0; c < 3; c++) begin
         step();
         check("bp_result", o_result, 32'hFF00);
         check("bp_valid", o_valid, 1'b1);
         check("bp_ready", o_ready, 1'b0);
         check("bp_pc", o_pc, 32'h106);
      end
      i_ready = 1'b1;
      #1;
      check("bp_release_ready", o_ready, 1'b1);
      step();
      check("and_valid", o_valid, 1'b1);
      check("and_result", o_result, 32'h0F);
      check("and_pc", o_pc, 32'h10A);

      // JAL backwards
      set_op(4'd0, 3'd0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b1);
      step();
      check("jal_pc", o_pc, 32'h106);
      check("jal_result", o_result, 32'h10E);
      check("jal_redirect", o_redirect, 1'b1);

      // Back-to-back single-cycle ops
      set_op(4'd4, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      step();
      check("sltu_result", o_result, 32'd0);
      check("sltu_pc", o_pc, 32'h10A);
      set_op(4'd3, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0);
      step();
      check("slt_result", o_result, 32'd1);
      check("slt_pc", o_pc, 32'h10E);
      set_op(4'd12, 3'd0, 1'b0, 1'b0, 1'b0, 32'd5, 32'd0, 32'd7, 1'b1);
      step();
      check("op12_result", o_result, 32'd0);
      check("op12_valid", o_valid, 1'b1);
      check("op12_pc", o_pc, 32'h112);

      // Shift by zero completes in one cycle
      set_op(4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 32'h1234, 32'd0, 32'd0, 1'b0);
      step();
      check("sll0_result", o_result, 32'h1234);
      check("sll0_ready", o_ready, 1'b1);
      check("sll0_pc", o_pc, 32'h116);

      // Reset during the third cycle of a shift by 10
      set_op(4'd2, 3'd0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd10, 32'd0, 1'b0);
      step();
      i_valid = 1'b0;
      check("sll10_pc", o_pc, 32'h11A);
      check("sll10_ready", o_ready, 1'b0);
      step();
      step();
      rst = 1'b1;
      #1;
      check("midrst_valid", o_valid, 1'b0);
      check("midrst_pc", o_pc, 32'h0);
      check("midrst_ready", o_ready, 1'b1);
      check("midrst_result", o_result, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      seen_valid = 1'b0;
      repeat (12) begin
         step();
         if (o_valid) seen_valid = 1'b1;
      end
      check("postrst_no_result", seen_valid, 1'b0);
      check("postrst_pc", o_pc, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
